// File: rtl/mul_sequencer.sv
// Sequencing controller for a shared unsigned sequential multiplier: takes RV64M
// multiply requests, feeds operand magnitudes, waits out the latency, and returns the signed/selected half.
module mul_sequencer #(
  parameter int unsigned XLEN    = 64,
  parameter int unsigned MUL_LAT = 64,
  parameter int unsigned TAG_W   = 5
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              flush,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_op,
  input  logic [XLEN-1:0]   req_a,
  input  logic [XLEN-1:0]   req_b,
  input  logic [TAG_W-1:0]  req_tag,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [XLEN-1:0]   rsp_data,
  output logic [TAG_W-1:0]  rsp_tag,
  output logic [XLEN-1:0]   mul_a,
  output logic [XLEN-1:0]   mul_b,
  output logic              mul_load,
  input  logic [2*XLEN-1:0] mul_p
);

  localparam int unsigned PW    = 2 * XLEN;
  localparam int unsigned CNT_W = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;

  localparam logic [1:0] OP_MUL    = 2'b00;
  localparam logic [1:0] OP_MULH   = 2'b01;
  localparam logic [1:0] OP_MULHSU = 2'b10;

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_RUN, S_FIX, S_RESP} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [1:0]       op_q, op_d;
  logic             neg_q, neg_d;
  logic [PW-1:0]    prod_q, prod_d;
  logic [XLEN-1:0]  mul_a_q, mul_a_d, mul_b_q, mul_b_d;
  logic             mul_load_q, mul_load_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [XLEN-1:0]  rsp_data_q, rsp_data_d;
  logic [TAG_W-1:0] rsp_tag_q, rsp_tag_d;

  logic             accept;
  logic             run_last;
  logic [PW-1:0]    prod_fix;

  function automatic logic [XLEN-1:0] abs_f(input logic [XLEN-1:0] v);
    return v[XLEN-1] ? (~v + XLEN'(1)) : v;
  endfunction

  assign req_ready = (state_q == S_IDLE) & ~flush & ~Rst;
  assign accept    = req_valid & req_ready;
  assign run_last  = (count_q == CNT_W'(MUL_LAT - 1));
  assign prod_fix  = neg_q ? (~prod_q + PW'(1)) : prod_q;

  // State register
  always_ff @(posedge Clk) begin
    if (Rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic; flush overrides every transition
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept) state_d = S_LOAD;
      S_LOAD:  state_d = S_RUN;
      S_RUN:   if (run_last) state_d = S_FIX;
      S_FIX:   state_d = S_RESP;
      S_RESP:  if (rsp_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (flush) state_d = S_IDLE;
  end

  // Datapath and registered-output next values
  always_comb begin
    count_d     = count_q;
    op_d        = op_q;
    neg_d       = neg_q;
    prod_d      = prod_q;
    mul_a_d     = mul_a_q;
    mul_b_d     = mul_b_q;
    mul_load_d  = 1'b0;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_tag_d   = rsp_tag_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          op_d       = req_op;
          rsp_tag_d  = req_tag;
          mul_load_d = 1'b1;
          mul_a_d    = (req_op == OP_MULH || req_op == OP_MULHSU) ? abs_f(req_a) : req_a;
          mul_b_d    = (req_op == OP_MULH) ? abs_f(req_b) : req_b;
          case (req_op)
            OP_MULH:   neg_d = req_a[XLEN-1] ^ req_b[XLEN-1];
            OP_MULHSU: neg_d = req_a[XLEN-1];
            default:   neg_d = 1'b0;
          endcase
        end
      end
      S_LOAD: count_d = '0;
      S_RUN: begin
        count_d = count_q + CNT_W'(1);
        if (run_last) prod_d = mul_p;
      end
      S_FIX: begin
        prod_d      = prod_fix;
        rsp_data_d  = (op_q == OP_MUL) ? prod_fix[XLEN-1:0] : prod_fix[PW-1:XLEN];
        rsp_valid_d = 1'b1;
      end
      S_RESP: if (rsp_ready) rsp_valid_d = 1'b0;
      default: ;
    endcase
    if (flush) begin
      mul_load_d  = 1'b0;
      rsp_valid_d = 1'b0;
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      count_q     <= '0;
      op_q        <= '0;
      neg_q       <= 1'b0;
      prod_q      <= '0;
      mul_a_q     <= '0;
      mul_b_q     <= '0;
      mul_load_q  <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_tag_q   <= '0;
    end else begin
      count_q     <= count_d;
      op_q        <= op_d;
      neg_q       <= neg_d;
      prod_q      <= prod_d;
      mul_a_q     <= mul_a_d;
      mul_b_q     <= mul_b_d;
      mul_load_q  <= mul_load_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_tag_q   <= rsp_tag_d;
    end
  end

  assign mul_a     = mul_a_q;
  assign mul_b     = mul_b_q;
  assign mul_load  = mul_load_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_tag   = rsp_tag_q;

endmodule

// File: tb/tb_mul_sequencer.sv
// Directed bench for mul_sequencer with a behavioural fixed-latency multiplier.
module tb_mul_sequencer;

  localparam int unsigned XLEN    = 64;
  localparam int unsigned MUL_LAT = 64;
  localparam int unsigned TAG_W   = 5;
  localparam logic [127:0] GARB   = 128'hA5A5_5A5A_C3C3_3C3C_0F0F_F0F0_9696_6969;

  logic              Clk = 1'b0;
  logic              Rst;
  logic              flush;
  logic              req_valid;
  logic              req_ready;
  logic [1:0]        req_op;
  logic [XLEN-1:0]   req_a, req_b;
  logic [TAG_W-1:0]  req_tag;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [XLEN-1:0]   rsp_data;
  logic [TAG_W-1:0]  rsp_tag;
  logic [XLEN-1:0]   mul_a, mul_b;
  logic              mul_load;
  logic [2*XLEN-1:0] mul_p;

  int tests  = 0;
  int failed = 0;

  mul_sequencer #(.XLEN(XLEN), .MUL_LAT(MUL_LAT), .TAG_W(TAG_W)) dut (
    .Clk(Clk), .Rst(Rst), .flush(flush),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b), .req_tag(req_tag),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_tag(rsp_tag),
    .mul_a(mul_a), .mul_b(mul_b), .mul_load(mul_load), .mul_p(mul_p)
  );

  always #5 Clk = ~Clk;

  // Multiplier model: product valid MUL_LAT edges after the load sample edge, garbage before
  logic [XLEN-1:0] ma = '0, mb = '0;
  int              mcnt = 1000;
  always @(posedge Clk) begin
    if (mul_load) begin
      ma   <= mul_a;
      mb   <= mul_b;
      mcnt <= 0;
    end else if (mcnt < 1000) begin
      mcnt <= mcnt + 1;
    end
  end
  assign mul_p = (mcnt >= int'(MUL_LAT) - 1) ? ({64'b0, ma} * {64'b0, mb}) : GARB;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [1:0] op, input logic [63:0] a, input logic [63:0] b,
                      input logic [4:0] tag);
    logic ok;
    ok        = 1'b0;
    req_op    = op;
    req_a     = a;
    req_b     = b;
    req_tag   = tag;
    req_valid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge Clk);
      if (req_ready) begin
        ok = 1'b1;
        break;
      end
      @(posedge Clk);
      #1;
    end
    @(posedge Clk);
    #1;
    req_valid = 1'b0;
    check("accept", 64'(ok), 64'd1);
  endtask

  task automatic wait_rsp(output int lat);
    logic got;
    got = 1'b0;
    lat = 1;
    for (int i = 0; i < 300; i++) begin
      @(negedge Clk);
      if (rsp_valid) begin
        got = 1'b1;
        break;
      end
      lat++;
      @(posedge Clk);
    end
    check("rsp_seen", 64'(got), 64'd1);
  endtask

  task automatic run_op(input string name, input logic [1:0] op, input logic [63:0] a,
                        input logic [63:0] b, input logic [4:0] tag, input logic [63:0] exp);
    int lat;
    send(op, a, b, tag);
    wait_rsp(lat);
    check({name, "_lat"}, 64'(lat), 64'd67);
    check({name, "_data"}, rsp_data, exp);
    check({name, "_tag"}, 64'(rsp_tag), 64'(tag));
    @(posedge Clk);
    #1;
  endtask

  initial begin
    int lat;
    int seen;
    Rst = 1'b1; flush = 1'b0; req_valid = 1'b0; req_op = '0;
    req_a = '0; req_b = '0; req_tag = '0; rsp_ready = 1'b1;

    // Reset state
    @(negedge Clk);
    check("rst_req_ready", 64'(req_ready), 64'd0);
    @(posedge Clk); @(posedge Clk); #1;
    Rst = 1'b0;
    @(negedge Clk);
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_mul_load", 64'(mul_load), 64'd0);
    check("rst_rsp_data", rsp_data, 64'd0);
    check("rst_mul_a", mul_a, 64'd0);
    check("idle_req_ready", 64'(req_ready), 64'd1);
    @(posedge Clk); #1;

    // Basic products and sign handling
    run_op("t1_mul", 2'b00, 64'd3, 64'd5, 5'd7, 64'd15);
    run_op("t2_mulh_neg", 2'b01, 64'hFFFF_FFFF_FFFF_FFFE, 64'd3, 5'd2, 64'hFFFF_FFFF_FFFF_FFFF);
    run_op("t2_mulh_min", 2'b01, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 5'd3,
           64'h4000_0000_0000_0000);
    run_op("t3_mulhu", 2'b11, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 5'd4,
           64'hFFFF_FFFF_FFFF_FFFE);
    run_op("t3_mulhsu", 2'b10, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 5'd5, 64'hFFFF_FFFF_FFFF_FFFF);
    run_op("t3_mul_m1", 2'b00, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 5'd6, 64'd1);
    run_op("t3_mulh_zero", 2'b01, 64'hFFFF_FFFF_FFFF_FFFB, 64'd0, 5'd8, 64'd0);

    // Backpressure in RESP with a queued request
    rsp_ready = 1'b0;
    send(2'b00, 64'd6, 64'd7, 5'd3);
    wait_rsp(lat);
    check("t4_lat", 64'(lat), 64'd67);
    req_op = 2'b11; req_a = 64'h8000_0000_0000_0000; req_b = 64'd4; req_tag = 5'd9;
    req_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge Clk); #1;
      @(negedge Clk);
      check("t4_hold_valid", 64'(rsp_valid), 64'd1);
      check("t4_hold_data", rsp_data, 64'd42);
      check("t4_hold_tag", 64'(rsp_tag), 64'd3);
      check("t4_hold_ready", 64'(req_ready), 64'd0);
    end
    @(posedge Clk); #1;
    rsp_ready = 1'b1;
    @(posedge Clk); #1;
    @(negedge Clk);
    check("t4_post_valid", 64'(rsp_valid), 64'd0);
    check("t4_post_ready", 64'(req_ready), 64'd1);
    @(posedge Clk); #1;
    req_valid = 1'b0;
    wait_rsp(lat);
    check("t4_q_lat", 64'(lat), 64'd67);
    check("t4_q_data", rsp_data, 64'd2);
    check("t4_q_tag", 64'(rsp_tag), 64'd9);
    @(posedge Clk); #1;

    // Flush mid-RUN at count 30
    send(2'b00, 64'd1, 64'd1, 5'd1);
    repeat (31) @(posedge Clk);
    #1;
    flush = 1'b1;
    @(negedge Clk);
    check("t5_flush_ready", 64'(req_ready), 64'd0);
    @(posedge Clk); #1;
    flush = 1'b0;
    @(negedge Clk);
    check("t5_idle_ready", 64'(req_ready), 64'd1);
    check("t5_mul_load", 64'(mul_load), 64'd0);
    seen = 0;
    for (int i = 0; i < 80; i++) begin
      @(negedge Clk);
      if (rsp_valid) seen++;
    end
    check("t5_no_rsp", 64'(seen), 64'd0);
    @(posedge Clk); #1;
    run_op("t5_after", 2'b00, 64'd6, 64'd7, 5'd4, 64'd42);

    // Synchronous reset mid-RUN
    send(2'b11, 64'd3, 64'd5, 5'd7);
    repeat (20) @(posedge Clk);
    #1;
    Rst = 1'b1;
    @(negedge Clk);
    check("t6_rst_ready", 64'(req_ready), 64'd0);
    @(posedge Clk); #1;
    Rst = 1'b0;
    @(negedge Clk);
    check("t6_rsp_valid", 64'(rsp_valid), 64'd0);
    check("t6_mul_load", 64'(mul_load), 64'd0);
    check("t6_rsp_data", rsp_data, 64'd0);
    check("t6_rsp_tag", 64'(rsp_tag), 64'd0);
    check("t6_mul_a", mul_a, 64'd0);
    check("t6_mul_b", mul_b, 64'd0);
    check("t6_req_ready", 64'(req_ready), 64'd1);
    @(posedge Clk); #1;
    run_op("t6_repeat", 2'b00, 64'd3, 64'd5, 5'd7, 64'd15);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
